// File: rtl/disc_param_if.sv
// disc_param_if: button/frame inputs and committed disc parameters of disc_param_ctrl
interface disc_param_if;
  logic       btn_c;
  logic       btn_u;
  logic       btn_d;
  logic       btn_l;
  logic       btn_r;
  logic       frame_start;
  logic [9:0] disc_x;
  logic [9:0] disc_y;
  logic [7:0] disc_r;
  logic [11:0] disc_color;
  logic [1:0] mode;
  logic       pending;
  modport master (output btn_c, btn_u, btn_d, btn_l, btn_r, frame_start,
                  input disc_x, disc_y, disc_r, disc_color, mode, pending);
  modport slave (input btn_c, btn_u, btn_d, btn_l, btn_r, frame_start,
                 output disc_x, disc_y, disc_r, disc_color, mode, pending);
endinterface

// File: rtl/disc_param_ctrl.sv
// disc_param_ctrl: button-edited shadow disc parameters, committed atomically at frame start
module disc_param_ctrl #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int STEP   = 4,
  parameter int R_MIN  = 8,
  parameter int R_MAX  = 120,
  parameter int R_INIT = 32
) (
  input  logic sys_clk,
  input  logic rst_n,
  disc_param_if.slave bus
);
  typedef enum logic [1:0] {POS = 2'd0, RAD = 2'd1, COL = 2'd2} mode_t;
  localparam logic signed [10:0] S11  = 11'(STEP);
  localparam logic signed [10:0] XMAX = 11'(H_RES - 1);
  localparam logic signed [10:0] YMAX = 11'(V_RES - 1);
  localparam logic [8:0] S9    = 9'(STEP);
  localparam logic [8:0] RMIN9 = 9'(R_MIN);
  localparam logic [8:0] RMAX9 = 9'(R_MAX);
  localparam logic [9:0] X0 = 10'(H_RES / 2);
  localparam logic [9:0] Y0 = 10'(V_RES / 2);
  localparam logic [7:0] R0 = 8'(R_INIT);
  localparam logic [11:0] PAL [8] = '{12'hFFF, 12'hF00, 12'h0F0, 12'h00F,
                                      12'hFF0, 12'h0FF, 12'hF0F, 12'h888};
  mode_t mode_q, mode_d;
  logic [9:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d, dx_q, dy_q;
  logic [7:0] sh_r_q, sh_r_d, dr_q;
  logic [2:0] pal_q, pal_d, dpal_q;
  logic pend_q, pend_d, changed;
  logic signed [10:0] x_lo, x_hi, y_lo, y_hi;
  logic [8:0] r_hi, r_lo;
  logic [9:0] x_dn, x_up, y_dn, y_up;
  logic [7:0] r_up, r_dn;
  // signed 11-bit steps so a decrement below zero saturates rather than wraps
  always_comb begin
    x_lo = $signed({1'b0, sh_x_q}) - S11;
    x_hi = $signed({1'b0, sh_x_q}) + S11;
    y_lo = $signed({1'b0, sh_y_q}) - S11;
    y_hi = $signed({1'b0, sh_y_q}) + S11;
    r_hi = {1'b0, sh_r_q} + S9;
    r_lo = {1'b0, sh_r_q} - S9;
    x_dn = x_lo < 0 ? '0 : x_lo[9:0];
    x_up = x_hi > XMAX ? XMAX[9:0] : x_hi[9:0];
    y_dn = y_lo < 0 ? '0 : y_lo[9:0];
    y_up = y_hi > YMAX ? YMAX[9:0] : y_hi[9:0];
    r_up = r_hi > RMAX9 ? RMAX9[7:0] : r_hi[7:0];
    r_dn = {1'b0, sh_r_q} < RMIN9 + S9 ? RMIN9[7:0] : r_lo[7:0];
  end
  always_comb begin
    mode_d = mode_q;
    sh_x_d = sh_x_q;
    sh_y_d = sh_y_q;
    sh_r_d = sh_r_q;
    pal_d  = pal_q;
    if (bus.btn_c) mode_d = mode_q == POS ? RAD : mode_q == RAD ? COL : POS;
    else if (bus.btn_u) begin
      sh_y_d = mode_q == POS ? y_dn : sh_y_q;
      sh_r_d = mode_q == RAD ? r_up : sh_r_q;
      pal_d  = mode_q == COL ? pal_q + 3'd1 : pal_q;
    end else if (bus.btn_d) begin
      sh_y_d = mode_q == POS ? y_up : sh_y_q;
      sh_r_d = mode_q == RAD ? r_dn : sh_r_q;
      pal_d  = mode_q == COL ? pal_q - 3'd1 : pal_q;
    end else if (bus.btn_l) sh_x_d = mode_q == POS ? x_dn : sh_x_q;
    else if (bus.btn_r) sh_x_d = mode_q == POS ? x_up : sh_x_q;
    changed = {sh_x_d, sh_y_d, sh_r_d, pal_d} != {sh_x_q, sh_y_q, sh_r_q, pal_q};
    pend_d = bus.frame_start ? changed : pend_q | changed;
  end
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= POS;
      sh_x_q <= X0;
      sh_y_q <= Y0;
      sh_r_q <= R0;
      pal_q  <= '0;
      dx_q   <= X0;
      dy_q   <= Y0;
      dr_q   <= R0;
      dpal_q <= '0;
      pend_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      sh_x_q <= sh_x_d;
      sh_y_q <= sh_y_d;
      sh_r_q <= sh_r_d;
      pal_q  <= pal_d;
      pend_q <= pend_d;
      if (bus.frame_start) begin
        dx_q   <= sh_x_q;
        dy_q   <= sh_y_q;
        dr_q   <= sh_r_q;
        dpal_q <= pal_q;
      end
    end
  end
  assign bus.disc_x     = dx_q;
  assign bus.disc_y     = dy_q;
  assign bus.disc_r     = dr_q;
  assign bus.disc_color = PAL[dpal_q];
  assign bus.mode       = mode_q;
  assign bus.pending    = pend_q;
endmodule

// File: doc/disc_param_ctrl.md
DISC_PARAM_CTRL -- requirements
Module: disc_param_ctrl

Interface
REQ-001 SHALL have parameter H_RES, default 640, meaning horizontal pixel count.
REQ-002 SHALL have parameter V_RES, default 480, meaning vertical line count.
REQ-003 SHALL have parameter STEP, default 4, meaning pixel increment per accepted press.
REQ-004 SHALL have parameters R_MIN, R_MAX, R_INIT, defaults 8, 120, 32, meaning radius floor, ceiling and reset value.
REQ-005 SHALL have port sys_clk, input, 1, meaning the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-007 SHALL have ports btn_c, btn_u, btn_d, btn_l, btn_r, input, 1 each, meaning one-cycle debounced one-shot press pulses.
REQ-008 SHALL have port frame_start, input, 1, meaning a one-cycle pulse at the start of vertical blanking.
REQ-009 SHALL have port disc_x, output, 10, meaning the committed centre column.
REQ-010 SHALL have port disc_y, output, 10, meaning the committed centre row.
REQ-011 SHALL have port disc_r, output, 8, meaning the committed radius.
REQ-012 SHALL have port disc_color, output, 12, meaning the committed RGB444 colour.
REQ-013 SHALL have port mode, output, 2, meaning current edit mode: 0 POS, 1 RAD, 2 COL.
REQ-014 SHALL have port pending, output, 1, meaning that shadow values differ from committed values.

Function
REQ-015 SHALL hold shadow registers sh_x, sh_y, sh_r and pal_idx[2:0] that are updated by button pulses.
REQ-016 SHALL load all committed outputs from the shadows on the cycle after frame_start, atomically, and at no other time.
REQ-017 SHALL accept at most one button action per cycle, with priority btn_c > btn_u > btn_d > btn_l > btn_r; lower-priority simultaneous pulses are dropped.
REQ-018 SHALL apply a shadow update on the clock edge where the pulse is sampled, giving 1-cycle latency to the shadow.
REQ-019 SHALL implement the mode FSM POS->RAD->COL->POS, advancing on btn_c; a state code of 3 SHALL go to POS.
REQ-020 SHALL use the mode value held before the edge to decode any action sampled on the same edge.
REQ-021 SHALL, in POS mode: btn_l decrements sh_x by STEP, btn_r increments sh_x, btn_u decrements sh_y, btn_d increments sh_y.
REQ-022 SHALL saturate position: sh_x stays in 0..H_RES-1 and sh_y stays in 0..V_RES-1; arithmetic is 11-bit signed, so no wrap.
REQ-023 SHALL, in RAD mode: btn_u adds STEP to sh_r with saturation at R_MAX, btn_d subtracts STEP with saturation at R_MIN, and btn_l/btn_r are no-ops.
REQ-024 SHALL, in COL mode: btn_u increments pal_idx and btn_d decrements it, wrapping modulo 8, and btn_l/btn_r are no-ops.
REQ-025 SHALL use the palette idx0..7 = FFF, F00, 0F0, 00F, FF0, 0FF, F0F, 888, with disc_color = palette[committed pal_idx].
REQ-026 SHALL treat a press whose result equals the current value (at a saturation limit) as a no-op that does not set pending.
REQ-027 SHALL set pending on any shadow value change and clear it on commit.
REQ-028 SHALL, when frame_start and a changing press coincide, commit the pre-press shadow values and leave pending=1.
REQ-029 SHALL not change mode on a commit, and btn_c alone SHALL NOT set pending.

Reset
REQ-030 SHALL, while rst_n=0, set sh_x=disc_x=H_RES/2, sh_y=disc_y=V_RES/2, sh_r=disc_r=R_INIT, pal_idx=0, disc_color=FFF, mode=0 and pending=0.
REQ-031 SHALL, when reset is asserted mid-operation, discard uncommitted shadow edits.
REQ-032 SHALL release reset without needing a clock edge to reach reset values, and SHALL ignore pulses sampled while rst_n=0.

Verification
REQ-033 SHALL be tested with btn_r x3 in POS mode then frame_start: disc_x stays 320 until 1 cycle after frame_start, then becomes 332, and pending goes 1 then 0.
REQ-034 SHALL be tested with btn_c once, then btn_u x30: sh_r saturates at 120, the 23rd and later presses are no-ops, and after commit disc_r=120.
REQ-035 SHALL be tested with btn_c x2 then btn_d once: pal_idx wraps to 7, and after commit disc_color=888.
REQ-036 SHALL be tested with btn_l x200 in POS mode: disc_x=0 after commit with no underflow; with btn_u and btn_l pulsed in the same cycle, only sh_y changes.
REQ-037 SHALL be tested with btn_d coincident with frame_start: the committed disc_y is unchanged (240), pending=1, and the next frame_start gives disc_y=244.
REQ-038 SHALL be tested with rst_n pulsed low after 5 uncommitted edits in RAD mode: all outputs return to reset values, mode=0 and pending=0.
